fifo9_byte_packer: RTL

- Downstream consumer of the 512x9 async FIFO, on the read-clock side.
- Pops 9-bit entries: bits 7:0 are a data byte, bit 8 is an end-of-packet marker. Packs the bytes little-endian into 32-bit words with byte-keep and last flags.
- Presents the words on a valid/ready stream to the packet sink.
- Drives the FIFO in standard (non first-word-fall-through) mode: data returns one cycle after the read enable, qualified by the FIFO's valid flag.

---
 rtl/fifo9_byte_packer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/fifo9_byte_packer.sv
// fifo9_byte_packer
// Read-side consumer of the 512x9 async FIFO. Pops 9-bit entries (byte plus
// end-of-packet marker), packs the bytes little-endian into 32-bit words and
// presents them with keep/last flags on a valid/ready stream.
// Optional feature macro: FIFO9_PACKER_TIMEOUT_EN. When defined, a partial
// word that sits idle for TimeoutCycles cycles is flushed with OutLast=0.
module fifo9_byte_packer #(
   parameter int TimeoutCycles = 64,
   parameter int CountWidth    = 16
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic [8:0]            FifoDout,
   input  logic                  FifoEmpty,
   input  logic                  FifoValid,
   output logic                  FifoRdEn,
   output logic [31:0]           OutData,
   output logic [3:0]            OutKeep,
   output logic                  OutLast,
   output logic                  OutValid,
   input  logic                  OutReady,
   output logic [CountWidth-1:0] PacketCount,
   output logic [CountWidth-1:0] ErrCount
);

   // The idle counter is 16 bits wide, so the timeout must fit in it.
   if (TimeoutCycles < 2 || TimeoutCycles > 65535) begin : gBadTimeout
      $error("TimeoutCycles out of range 2..65535");
   end

   logic                  pending_q;
   logic [1:0]            byteIdx_q;
   logic [31:0]           acc_q;
   logic [31:0]           outData_q;
   logic [3:0]            outKeep_q;
   logic                  outLast_q;
   logic                  outValid_q;
   logic [CountWidth-1:0] pktCnt_q;
   logic [CountWidth-1:0] errCnt_q;

   logic        outFree;
   logic        byteRet;
   logic        stray;
   logic        complete;
   logic        flush;
   logic [31:0] wordD;
   logic [3:0]  keepD;
   logic [3:0]  flushKeep;

   assign outFree  = !outValid_q || OutReady;
   assign byteRet  = FifoValid && pending_q;
   assign stray    = FifoValid && !pending_q;
   assign complete = byteRet && ((byteIdx_q == 2'd3) || FifoDout[8]);

`ifdef FIFO9_PACKER_TIMEOUT_EN
   localparam logic [15:0] TimeoutLim = 16'(TimeoutCycles);

   logic [15:0] idle_q;

   assign flush = (byteIdx_q != 2'd0) && !pending_q && (idle_q >= TimeoutLim) && outFree;

   // Count idle cycles while a partial word waits with no read in flight;
   // a flush that cannot happen yet keeps the counter parked at the limit.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         idle_q <= '0;
      end else if (byteRet || (byteIdx_q == 2'd0) || flush) begin
         idle_q <= '0;
      end else if (!pending_q && (idle_q < TimeoutLim)) begin
         idle_q <= idle_q + 16'd1;
      end
   end
`else
   assign flush = 1'b0;
`endif

   // A read is blocked on a flush cycle so its byte cannot complete a word
   // against the freshly loaded (and possibly stalled) output register.
   assign FifoRdEn = !Reset && !FifoEmpty && !pending_q && outFree && !flush;

   // Build the completed word by dropping the returning byte into its lane;
   // lanes above it are still zero because the accumulator clears per word.
   always_comb begin
      wordD = acc_q;
      wordD[{byteIdx_q, 3'b000} +: 8] = FifoDout[7:0];
      unique case (byteIdx_q)
         2'd0: begin keepD = 4'b0001; flushKeep = 4'b0000; end
         2'd1: begin keepD = 4'b0011; flushKeep = 4'b0001; end
         2'd2: begin keepD = 4'b0111; flushKeep = 4'b0011; end
         default: begin keepD = 4'b1111; flushKeep = 4'b0111; end
      endcase
   end

   // Read tracking, byte accumulation, output register and counters.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         pending_q  <= 1'b0;
         byteIdx_q  <= 2'd0;
         acc_q      <= '0;
         outData_q  <= '0;
         outKeep_q  <= '0;
         outLast_q  <= 1'b0;
         outValid_q <= 1'b0;
         pktCnt_q   <= '0;
         errCnt_q   <= '0;
      end else begin
         if (FifoRdEn) begin
            pending_q <= 1'b1;
         end else if (byteRet) begin
            pending_q <= 1'b0;
         end

         if (complete) begin
            outData_q <= wordD;
            outKeep_q <= keepD;
            outLast_q <= FifoDout[8];
            byteIdx_q <= 2'd0;
            acc_q     <= '0;
         end else if (byteRet) begin
            acc_q[{byteIdx_q, 3'b000} +: 8] <= FifoDout[7:0];
            byteIdx_q <= byteIdx_q + 2'd1;
         end else if (flush) begin
            outData_q <= acc_q;
            outKeep_q <= flushKeep;
            outLast_q <= 1'b0;
            byteIdx_q <= 2'd0;
            acc_q     <= '0;
         end

         if (complete || flush) begin
            outValid_q <= 1'b1;
         end else if (OutReady) begin
            outValid_q <= 1'b0;
         end

         if (outValid_q && OutReady && outLast_q) begin
            pktCnt_q <= pktCnt_q + 1'b1;
         end

         if (stray && (errCnt_q != {CountWidth{1'b1}})) begin
            errCnt_q <= errCnt_q + 1'b1;
         end
      end
   end

   // Reads are only issued into a free or draining register, so a completing
   // byte must never find the register holding a stalled word.
   assert property (@(posedge Clk) disable iff (Reset) complete |-> outFree)
      else $error("completing byte met a held output register");

   assign OutData     = outData_q;
   assign OutKeep     = outKeep_q;
   assign OutLast     = outLast_q;
   assign OutValid    = outValid_q;
   assign PacketCount = pktCnt_q;
   assign ErrCount    = errCnt_q;

endmodule
